// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_pkg
// Brief    : Shared LC-3 constants: writeback requester indices and
//            register-file geometry.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_pkg;

  // Writeback requester indices into the request vectors
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;

  // Register file geometry
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;

  // Width of the completed-write counter
  localparam int COUNT_W  = 16;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Brief    : Writeback request bus plus register-file write bus seen by the
//            register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ  = lc3_pkg::REQ_LINK + 1,
  parameter int DATA_W   = lc3_pkg::DATA_W,
  parameter int NUM_REGS = lc3_pkg::NUM_REGS,
  parameter int ADDR_W   = lc3_pkg::ADDR_W
) ();
  import lc3_pkg::*;

  // Requester side
  logic                       hold;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;

  // Register-file side and status
  logic [NUM_REGS-1:0]        reg_enable;
  logic [DATA_W-1:0]          reg_data;
  logic [NUM_REQ-1:0]         last_grant;
  logic [COUNT_W-1:0]         write_count;

  // Pipeline / register-file environment
  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, reg_enable, reg_data, last_grant, write_count
  );

  // The arbiter itself
  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, reg_enable, reg_data, last_grant, write_count
  );

endinterface : regfile_write_arbiter_if
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. The search starts at the
//            index after the one-hot last grant and wraps; the first
//            requesting index wins. No grant while enable is low.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_grant_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o
);
  import lc3_pkg::*;

  int   base;
  int   idx;
  logic found;

  // Rotating-priority search starting one past the previous winner
  always_comb begin
    grant_o = '0;
    base    = 0;
    idx     = 0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_grant_i[i]) begin
        base = i;
      end
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = base + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (enable_i && !found && req_i[j] && (idx == j)) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Shares the single LC-3 register-file write port between the
//            writeback sources. One source is granted per cycle by
//            round-robin; its address/data are captured and driven to the
//            register file as a one-hot enable on the following cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int NUM_REQ  = lc3_pkg::REQ_LINK + 1,
  parameter int DATA_W   = lc3_pkg::DATA_W,
  parameter int NUM_REGS = lc3_pkg::NUM_REGS,
  parameter int ADDR_W   = lc3_pkg::ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);
  import lc3_pkg::*;

  // After reset the pointer sits on the last requester so index 0 wins first
  localparam logic [NUM_REQ-1:0] LAST_GRANT_RST = NUM_REQ'(1) << (NUM_REQ - 1);

  logic [NUM_REQ-1:0]  grant;
  logic                grant_en;
  logic                accept;
  logic                write_now;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] dec;

  logic [NUM_REQ-1:0]  last_grant_q, last_grant_d;
  logic                wr_valid_q,   wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
  logic [COUNT_W-1:0]  count_q,      count_d;

  // Grants are suppressed during hold and during the reset cycle
  assign grant_en = !bus.hold && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (grant_en),
    .grant_o      (grant)
  );

  // Grant is only ever raised on a valid requester, so any grant is a handshake
  assign accept        = |grant;
  assign bus.req_ready = grant;

  // Route the granted requester's address and data to the capture registers
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: capture on acceptance, count each issued write
  always_comb begin
    last_grant_d = last_grant_q;
    wr_valid_d   = accept;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    count_d      = count_q;
    if (accept) begin
      last_grant_d = grant;
      wr_addr_d    = sel_addr;
      wr_data_d    = sel_data;
    end
    if (wr_valid_q) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // State registers; reset also drops a write accepted on the previous edge
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= LAST_GRANT_RST;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      count_q      <= count_d;
    end
  end

  // A pending write is discarded if reset arrives in its write cycle
  assign write_now = wr_valid_q && !reset;

  // One-hot address decoder; indices beyond the file decode to no enable
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_dec
    assign dec[r] = write_now && (wr_addr_q == ADDR_W'(r));
  end

  assign bus.reg_enable  = dec;
  assign bus.reg_data    = wr_data_q;
  assign bus.last_grant  = last_grant_q;
  assign bus.write_count = count_q;

endmodule : regfile_write_arbiter
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the LC-3 8x16 register file between NUM_REQ writeback sources: 0 = ALU, 1 = memory load, 2 = R7 link for JSR/TRAP. The block selects one source per cycle by round-robin and registers its address and data. On the next cycle it drives a one-hot enable vector and shared write data to the eight 16-bit register instances. It sits between the execute/memory stages and the register file, and is the only block that asserts register enables.

Parameters:
NUM_REQ, 3, number of write requesters
DATA_W, 16, register width
NUM_REGS, 8, registers in the file
ADDR_W, 3, register index width (log2 NUM_REGS)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
hold  input  1  freeze: no new grants while high
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  destination register index, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; handshake completes when valid and ready are both high
reg_enable  output  NUM_REGS  one-hot write enable to register i, or all zero
reg_data  output  DATA_W  write data shared by all registers
last_grant  output  NUM_REQ  one-hot index of the most recently granted requester
write_count  output  16  completed writes, wraps at 0xFFFF -> 0

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - reg_enable = 0, reg_data = 0, write_count = 0.
  - last_grant = 1 << (NUM_REQ-1), so requester 0 has first priority.
  - req_ready = 0 for the cycle in which reset is high.
- Grant (combinational, from registered pointer state):
  - Search starts at the index after last_grant and wraps modulo NUM_REQ.
  - The first index with req_valid set receives req_ready.
  - At most one ready bit is high per cycle. req_ready is 0 when hold or reset is high.
- Acceptance at edge N (req_valid[i] and req_ready[i] both high):
  - Capture req_addr[i] and req_data[i].
  - last_grant <= one-hot(i).
- Write cycle N+1:
  - reg_enable = one-hot(captured addr) for exactly one cycle; reg_data = captured data.
  - The register file captures at the end of N+1. Latency from acceptance to register update is 1 cycle.
- Throughput: one write per cycle, back-to-back. reg_enable may stay high on consecutive cycles with different indices.
- Idle: with no acceptance, reg_enable = 0 on the next cycle. reg_data keeps its last value, which is don't-care while reg_enable is 0.
- Requester obligation: hold valid, addr and data stable until ready. Dropping valid before ready is legal; the request is simply not taken.
- Fairness: a continuously requesting source is granted within NUM_REQ cycles, with hold low.
- Same destination: two requests to the same register on consecutive cycles produce two writes in grant order; the last write wins.
- hold:
  - Blocks new grants only.
  - A write already accepted still completes on the next cycle.
  - last_grant is unchanged while hold is high.
- Reset mid-operation: a pending write (accepted on the previous cycle) is discarded. reg_enable = 0 on the cycle after reset.
- write_count increments on every cycle in which reg_enable is nonzero.
- Out-of-range addr (when NUM_REGS < 2^ADDR_W): reg_enable = 0, and the write is still counted.

Decomposition:
- Shared package lc3_pkg: constants REQ_ALU = 0, REQ_LOAD = 1, REQ_LINK = 2, NUM_REGS, DATA_W, ADDR_W.
- One sub-module, rr_arbiter:
  - Parameterised on NUM_REQ.
  - Inputs: req vector, last_grant, enable.
  - Output: one-hot grant.
  - Purely combinational, and reusable by the memory-port arbiter.
- Top level contains: the pointer register, the capture registers, the one-hot address decoder and the counter.

Test Plan:
- Reset then idle: reset high 2 cycles -> reg_enable = 0, write_count = 0, last_grant = 3'b100; with no requests, outputs stay at these values.
- Single write: req_valid = 3'b001, addr = 5, data = 0x1234 -> req_ready = 3'b001 at cycle N; at N+1 reg_enable = 8'b0010_0000 and reg_data = 0x1234; write_count = 1.
- Round-robin: all three valid continuously with addrs 1, 2, 7 -> grants 0, 1, 2, 0, ... on consecutive cycles; reg_enable sequence 0x02, 0x04, 0x80, 0x02.
- hold: all valid, hold high 3 cycles -> req_ready = 0 throughout; a write accepted just before hold still appears; after hold falls, grant resumes at the next index.
- Same register: ALU writes R3 = 0xAAAA, then load writes R3 = 0x5555 the next cycle -> two enables on R3; final reg_data = 0x5555; write_count += 2.
- Reset mid-write: accept R4 = 0xBEEF, assert reset on the next cycle -> reg_enable stays 0, write_count = 0, last_grant = 3'b100.
